// File: rtl/uart_pkg.sv
// Shared UART register map, Wishbone write-enable encoding and master FSM state encoding.
package uart_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] TX_DATA_ADDR  = 2'd0;
    localparam logic [ADDR_W-1:0] RX_DATA_ADDR  = 2'd1;
    localparam logic [ADDR_W-1:0] FREQ_DIV_ADDR = 2'd2;

    // The UART treats we=0 as a write into its registers.
    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } wbm_state_t;

endpackage

// File: rtl/uart_wb_master.sv
// Wishbone master feeding the UART: programs the divider after reset, then forwards
// TX bytes and divider updates as single paced writes, flagging unacknowledged strobes.
module uart_wb_master
    import uart_pkg::*;
#(
    parameter int unsigned DIVIDER  = 6,
    parameter int unsigned BYTE_GAP = 1200,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              wb_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] cfg_div,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              wb_we,
    output logic              wb_stb,
    input  logic              wb_ack,
    output logic              busy,
    output logic              err
);

    localparam logic [DATA_W-1:0] DIV_INIT = DATA_W'(DIVIDER);
    localparam logic [15:0]       GAP_LAST = 16'(BYTE_GAP - 1);
    localparam logic [8:0]        TMO_END  = 9'(TIMEOUT);

    wbm_state_t  state;
    logic [7:0]  tmo_cnt;
    logic [15:0] gap_cnt;
    logic        tmo_hit;

    // Abort on the cycle whose increment would bring the counter to TIMEOUT,
    // so wb_stb is high for exactly TIMEOUT cycles.
    assign tmo_hit = (9'({1'b0, tmo_cnt}) + 9'd1) == TMO_END;

    // Handshake readiness is decoded from the state register; cfg wins over tx.
    assign cfg_ready = (state == ST_IDLE);
    assign tx_ready  = (state == ST_IDLE) && !cfg_valid;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            state       <= ST_INIT;
            wb_stb      <= 1'b0;
            wb_we       <= WE_READ;
            wb_addr     <= '0;
            wb_data_out <= '0;
            err         <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_INIT: begin
                    wb_addr     <= FREQ_DIV_ADDR;
                    wb_data_out <= DIV_INIT;
                    wb_we       <= WE_WRITE;
                    wb_stb      <= 1'b1;
                    tmo_cnt     <= '0;
                    state       <= ST_STROBE;
                end
                ST_IDLE: begin
                    if (cfg_valid) begin
                        wb_addr     <= FREQ_DIV_ADDR;
                        wb_data_out <= cfg_div;
                        wb_we       <= WE_WRITE;
                        wb_stb      <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_STROBE;
                    end else if (tx_valid) begin
                        wb_addr     <= TX_DATA_ADDR;
                        wb_data_out <= tx_data;
                        wb_we       <= WE_WRITE;
                        wb_stb      <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (wb_ack) begin
                        wb_stb <= 1'b0;
                        wb_we  <= WE_READ;
                        state  <= ST_RELEASE;
                    end else if (tmo_hit) begin
                        wb_stb <= 1'b0;
                        wb_we  <= WE_READ;
                        err    <= 1'b1;
                        state  <= ST_RELEASE;
                    end else if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // Only TX writes need pacing; divider writes return straight to IDLE.
                    if (!wb_ack) begin
                        if (wb_addr == TX_DATA_ADDR) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: a small UART ack model plus a scoreboard of expected writes
// checked at every wb_stb rising edge.
module tb_uart_wb_master;
    import uart_pkg::*;

    localparam int unsigned DIVIDER  = 6;
    localparam int unsigned BYTE_GAP = 20;
    localparam int unsigned TIMEOUT  = 10;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       wb_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] cfg_div;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack = 1'b0;
    logic       busy;
    logic       err;

    int  ack_mode = 0;  // 0 normal, 1 never ack, 2 hold ack after stb drops
    int  hold_cnt = 0;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  last_rise = 0;
    int  last_ack_fall = 0;
    int  n_rise = 0;
    logic prev_stb = 1'b0;
    logic prev_ack = 1'b0;
    logic [1:0] held_addr = '0;
    logic [7:0] held_data = '0;
    wr_t exp_q[$];

    uart_wb_master #(
        .DIVIDER (DIVIDER),
        .BYTE_GAP(BYTE_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk     (wb_clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cfg_div    (cfg_div),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .wb_addr    (wb_addr),
        .wb_data_out(wb_data_out),
        .wb_we      (wb_we),
        .wb_stb     (wb_stb),
        .wb_ack     (wb_ack),
        .busy       (busy),
        .err        (err)
    );

    always #5 wb_clk = ~wb_clk;

    // UART acknowledge model.
    always_ff @(posedge wb_clk) begin
        case (ack_mode)
            0: wb_ack <= wb_stb && !wb_ack;
            1: wb_ack <= 1'b0;
            default: begin
                if (wb_stb && !wb_ack) begin
                    wb_ack   <= 1'b1;
                    hold_cnt <= 4;
                end else if (wb_ack && !wb_stb) begin
                    if (hold_cnt == 0) wb_ack <= 1'b0;
                    else hold_cnt <= hold_cnt - 1;
                end
            end
        endcase
    end

    // Advance to the next falling edge and run the write monitor.
    task automatic step();
        wr_t e;
        @(negedge wb_clk);
        cyc++;
        if (wb_stb && !prev_stb) begin
            last_rise = cyc;
            n_rise++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h we=%b, required no write", wb_addr, wb_data_out, wb_we);
            end else begin
                e = exp_q.pop_front();
                if ({wb_addr, wb_data_out, wb_we} !== {e.addr, e.data, 1'b0}) begin
                    errors++;
                    $display("FAIL write_content: addr=%0d data=%h we=%b, required addr=%0d data=%h we=0",
                             wb_addr, wb_data_out, wb_we, e.addr, e.data);
                end
            end
            checks++;
            if (wb_ack !== 1'b0) begin
                errors++;
                $display("FAIL stb_during_ack: wb_ack=%b at stb rise, required 0", wb_ack);
            end
        end else if (wb_stb && prev_stb) begin
            checks++;
            if (wb_addr !== held_addr || wb_data_out !== held_data) begin
                errors++;
                $display("FAIL strobe_stable: addr=%0d data=%h, required addr=%0d data=%h",
                         wb_addr, wb_data_out, held_addr, held_data);
            end
        end
        if (!wb_ack && prev_ack) last_ack_fall = cyc;
        prev_stb  = wb_stb;
        prev_ack  = wb_ack;
        held_addr = wb_addr;
        held_data = wb_data_out;
    endtask

    task automatic wait_idle(input int bound, input string name, output int n);
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    // Offer a TX byte, wait for tx_ready, complete the handshake; returns the ready cycle.
    task automatic send_tx(input logic [7:0] d, output int ready_cyc);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back('{addr: TX_DATA_ADDR, data: d});
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ready_cyc = cyc;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
        step();
        tx_valid = 1'b0;
        checks++;
        if (wb_stb !== 1'b1) begin
            errors++;
            $display("FAIL stb_latency: wb_stb=%b one cycle after handshake, required 1", wb_stb);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({wb_stb, wb_we, wb_addr, wb_data_out, tx_ready, cfg_ready, err, busy} !==
            {1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s: stb=%b we=%b addr=%0d data=%h txr=%b cfgr=%b err=%b busy=%b, required 0 1 0 00 0 0 0 1",
                     name, wb_stb, wb_we, wb_addr, wb_data_out, tx_ready, cfg_ready, err, busy);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) step();
        check_reset_outputs("reset_values");
        exp_q.push_back('{addr: FREQ_DIV_ADDR, data: 8'(DIVIDER)});
        reset = 1'b0;
        wait_idle(10, "init_no_gap", n);
        checks++;
        if (tx_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: tx_ready=%b cfg_ready=%b, required 1 1", tx_ready, cfg_ready);
        end
        checks++;
        if (n_rise !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL init_write_count: writes=%0d pending=%0d, required 1 0", n_rise, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int r1, r2, fall1, gap_entry;
        send_tx(8'h55, r1);
        send_tx(8'hA3, r2);
        fall1     = last_ack_fall;
        gap_entry = fall1 + 1;
        checks++;
        if (r2 - gap_entry < int'(BYTE_GAP) || r2 - gap_entry > int'(BYTE_GAP) + 2) begin
            errors++;
            $display("FAIL gap_tx_ready: tx_ready after %0d cycles of GAP, required %0d..%0d",
                     r2 - gap_entry, BYTE_GAP, BYTE_GAP + 2);
        end
        checks++;
        if (last_rise - gap_entry < int'(BYTE_GAP)) begin
            errors++;
            $display("FAIL gap_stb: second stb rise %0d cycles after release, required >= %0d",
                     last_rise - gap_entry, BYTE_GAP);
        end
        wait_idle(100, "b2b_idle", r1);
    endtask

    task automatic test_priority();
        int n, r1;
        cfg_div   = 8'd12;
        cfg_valid = 1'b1;
        tx_data   = 8'h41;
        tx_valid  = 1'b1;
        exp_q.push_back('{addr: FREQ_DIV_ADDR, data: 8'd12});
        exp_q.push_back('{addr: TX_DATA_ADDR, data: 8'h41});
        #1;
        checks++;
        if (tx_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_priority: tx_ready=%b cfg_ready=%b, required 0 1", tx_ready, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        r1 = last_rise;
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        tx_valid = 1'b0;
        checks++;
        if (last_rise - r1 <= 0 || last_rise - r1 >= int'(BYTE_GAP)) begin
            errors++;
            $display("FAIL cfg_no_gap: tx stb rise %0d cycles after cfg stb rise, required 1..%0d",
                     last_rise - r1, BYTE_GAP - 1);
        end
        wait_idle(100, "priority_idle", n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL priority_pending: %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int r, stb_hi, err_hi, err_cyc, fall_cyc;
        ack_mode = 1;
        send_tx(8'h99, r);
        stb_hi = 1; err_hi = 0; err_cyc = -1; fall_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wb_stb === 1'b1) stb_hi++;
            else if (fall_cyc < 0) fall_cyc = cyc;
            if (err === 1'b1) begin
                err_hi++;
                err_cyc = cyc;
            end
        end
        checks++;
        if (stb_hi != int'(TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_len: wb_stb high %0d cycles, required %0d", stb_hi, TIMEOUT);
        end
        checks++;
        if (err_hi != 1 || err_cyc != fall_cyc) begin
            errors++;
            $display("FAIL timeout_err: err high %0d cycles at cycle %0d, required 1 at cycle %0d",
                     err_hi, err_cyc, fall_cyc);
        end
        ack_mode = 0;
        wait_idle(100, "timeout_idle", r);
        send_tx(8'hB2, r);
        wait_idle(100, "after_timeout_idle", r);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_timeout_send: %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_ack_hold();
        int n;
        ack_mode  = 2;
        cfg_div   = 8'd9;
        cfg_valid = 1'b1;
        exp_q.push_back('{addr: FREQ_DIV_ADDR, data: 8'd9});
        step();
        cfg_valid = 1'b0;
        tx_data   = 8'h3C;
        tx_valid  = 1'b1;
        exp_q.push_back('{addr: TX_DATA_ADDR, data: 8'h3C});
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        tx_valid = 1'b0;
        checks++;
        if (last_rise - last_ack_fall < 2) begin
            errors++;
            $display("FAIL release_wait: stb rose %0d cycles after ack fell, required >= 2",
                     last_rise - last_ack_fall);
        end
        wait_idle(100, "ack_hold_idle", n);
        ack_mode = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ack_hold_pending: %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int r, rises;
        ack_mode = 1;
        send_tx(8'h7E, r);
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("reset_mid_strobe");
        ack_mode = 0;
        exp_q.push_back('{addr: FREQ_DIV_ADDR, data: 8'(DIVIDER)});
        reset = 1'b0;
        wait_idle(20, "reset_mid_idle", r);
        rises = n_rise;
        repeat (40) step();
        checks++;
        if (n_rise != rises || exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_resend: extra writes=%0d pending=%0d, required 0 0", n_rise - rises, exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        cfg_div   = 8'h00;
        cfg_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_priority();
        test_timeout();
        test_ack_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
